// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with enable, cascadable terminal count and
// optional parallel load with per-digit validation (BCD_UPDOWN_COUNTER_LOAD_EN).
module bcd_updown_counter #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // carry[i] means a step (increment or decrement) enters digit i this cycle.
  // carry[DIGITS] is therefore "every digit is at its wrap point while enabled".
  logic [DIGITS:0] carry;
  logic [W-1:0]    step_count;

  always_comb begin : step_logic
    logic [3:0] d;
    logic       at_end;
    carry      = '0;
    step_count = count;
    d          = 4'd0;
    at_end     = 1'b0;
    carry[0]   = en;
    for (int i = 0; i < DIGITS; i++) begin
      d          = count[4*i +: 4];
      at_end     = up ? (d == 4'd9) : (d == 4'd0);
      carry[i+1] = carry[i] & at_end;
      if (carry[i]) begin
        if (up) step_count[4*i +: 4] = at_end ? 4'd0 : d + 4'd1;
        else    step_count[4*i +: 4] = at_end ? 4'd9 : d - 4'd1;
      end
    end
  end

`ifdef BCD_UPDOWN_COUNTER_LOAD_EN
  logic [W-1:0] load_fixed;
  logic         load_bad;

  // Non-BCD digits are replaced by zero and flagged.
  always_comb begin
    load_fixed = '0;
    load_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) load_bad = 1'b1;
      else                             load_fixed[4*i +: 4] = load_value[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      load_err <= 1'b0;
    end else if (load) begin
      count    <= load_fixed;
      load_err <= load_bad;
    end else begin
      count    <= step_count;
      load_err <= 1'b0;
    end
  end

  assign tc = carry[DIGITS] & ~load & ~reset;
`else
  logic unused_load_inputs;
  assign unused_load_inputs = ^{load, load_value};

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= step_count;
  end

  assign load_err = 1'b0;
  assign tc       = carry[DIGITS] & ~reset;
`endif

endmodule
